counter_updown_mod: RTL and testbench

// - Parametrised successor to the fixed 8-bit up-counter: WIDTH-bit up/down counter with a

---
 rtl/counter_updown_mod.sv | 98 +++++++++
 tb/tb_counter_updown_mod.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// WIDTH-bit up/down event/timebase counter with a programmable modulo limit, parallel load,
// wrap or saturate boundary mode, an enable prescaler and a registered one-cycle wrap strobe.
module counter_updown_mod #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_saturate,
   input  logic [WIDTH-1:0] i_limit,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_wrap
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("counter_updown_mod: WIDTH must be >= 2");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("counter_updown_mod: PRESCALE must be >= 1");
      end
   endgenerate

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             wrap_q, wrap_d;
   logic             step;

   // Load beats the prescaler; with PRESCALE=1 the prescaler stays at 0 and every enabled cycle steps.
   always_comb begin
      presc_d = presc_q;
      step    = 1'b0;
      if (i_load) begin
         presc_d = '0;
      end else if (i_en) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            step    = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (i_load) begin
         count_d = i_load_val;
      end else if (step) begin
         if (i_up) begin
            // At or above the limit: saturate clamps to the limit, wrap returns to zero.
            if (count_q >= i_limit) begin
               if (i_saturate) begin
                  count_d = i_limit;
               end else begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               if (!i_saturate) begin
                  count_d = i_limit;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_q <= '0;
         presc_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         wrap_q  <= wrap_d;
      end
   end

   assign o_count = count_q;
   assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: PRESCALE=1 and PRESCALE=4 instances share stimulus; a reference
// model fills per-instance expected queues, plus directed checks against hand-derived values.
module tb_counter_updown_mod;

   logic       clk = 1'b0;
   logic       rst, en, up, sat, ld;
   logic [7:0] lim, lv;
   logic [7:0] c1, c4;
   logic       w1, w4;

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] exp1_q[$];
   logic [8:0] exp4_q[$];
   logic [7:0] m_c[2];
   int         m_p[2];
   logic       m_w[2];

   always #5 clk = ~clk;

   counter_updown_mod #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_up(up), .i_saturate(sat),
      .i_limit(lim), .i_load(ld), .i_load_val(lv), .o_count(c1), .o_wrap(w1)
   );

   counter_updown_mod #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_up(up), .i_saturate(sat),
      .i_limit(lim), .i_load(ld), .i_load_val(lv), .o_count(c4), .o_wrap(w4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_in(input logic r, input logic e, input logic u, input logic s,
                         input logic [7:0] l, input logic d, input logic [7:0] v);
      rst = r; en = e; up = u; sat = s; lim = l; ld = d; lv = v;
   endtask

   // Reference behaviour for one clock edge, for both prescale settings.
   task automatic model_edge();
      int pres;
      bit stp;
      for (int k = 0; k < 2; k++) begin
         pres    = (k == 0) ? 1 : 4;
         m_w[k]  = 1'b0;
         stp     = 1'b0;
         if (rst) begin
            m_c[k] = 8'd0;
            m_p[k] = 0;
         end else if (ld) begin
            m_c[k] = lv;
            m_p[k] = 0;
         end else if (en) begin
            m_p[k] = m_p[k] + 1;
            if (m_p[k] == pres) begin
               m_p[k] = 0;
               stp    = 1'b1;
            end
         end
         if (stp && up) begin
            if (m_c[k] >= lim) begin
               if (sat) m_c[k] = lim;
               else begin
                  m_c[k] = 8'd0;
                  m_w[k] = 1'b1;
               end
            end else begin
               m_c[k] = m_c[k] + 8'd1;
            end
         end else if (stp && !up) begin
            if (m_c[k] == 8'd0) begin
               if (!sat) begin
                  m_c[k] = lim;
                  m_w[k] = 1'b1;
               end
            end else begin
               m_c[k] = m_c[k] - 8'd1;
            end
         end
      end
      exp1_q.push_back({m_w[0], m_c[0]});
      exp4_q.push_back({m_w[1], m_c[1]});
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check("q1_nonempty", exp1_q.size(), 1);
      if (exp1_q.size() > 0) check("dut1_wrap_count", {w1, c1}, exp1_q.pop_front());
      check("q4_nonempty", exp4_q.size(), 1);
      if (exp4_q.size() > 0) check("dut4_wrap_count", {w4, c4}, exp4_q.pop_front());
   endtask

   initial begin
      m_c[0] = 8'd0; m_c[1] = 8'd0;
      m_p[0] = 0;    m_p[1] = 0;
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 8'd0);
      @(negedge clk);
      tick(); tick();
      check("rst_count", c1, 0);
      check("rst_wrap", w1, 0);
      check("rst_count4", c4, 0);

      set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_up", c1, i + 1);
      end

      // Up wrap with limit 9
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'd9, 1'b1, 8'd0);
      tick();
      ld = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("up_wrap_count", c1, (i < 9) ? i + 1 : i - 9);
         check("up_wrap_pulse", w1, (i == 9) ? 1 : 0);
      end

      // Down wrap then down saturate from 1, limit 5
      for (int s = 0; s < 2; s++) begin
         set_in(1'b0, 1'b1, 1'b0, s[0], 8'd5, 1'b1, 8'd1);
         tick();
         ld = 1'b0;
         tick();
         check("down_to_zero", c1, 0);
         check("down_to_zero_w", w1, 0);
         tick();
         check("down_bound", c1, (s == 0) ? 5 : 0);
         check("down_bound_w", w1, (s == 0) ? 1 : 0);
         tick();
         check("down_after", c1, (s == 0) ? 4 : 0);
         check("down_after_w", w1, 0);
      end

      // Load above limit, then one up step
      for (int s = 0; s < 2; s++) begin
         set_in(1'b0, 1'b1, 1'b1, s[0], 8'd100, 1'b1, 8'd200);
         tick();
         check("load_prio", c1, 200);
         ld = 1'b0;
         tick();
         check("above_lim_step", c1, (s == 0) ? 0 : 100);
         check("above_lim_w", w1, (s == 0) ? 1 : 0);
      end

      // Limit 0 in wrap mode: pulse on every step
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0);
      tick();
      ld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lim0_count", c1, 0);
         check("lim0_pulse", w1, 1);
      end

      // Prescale 4: continuous enable, then a 2-cycle enable gap
      set_in(1'b1, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 8'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("p4_cont", c4, (i == 3) ? 1 : 0);
      end
      tick(); tick();
      en = 1'b0;
      tick(); tick();
      check("p4_gap_hold", c4, 1);
      en = 1'b1;
      tick();
      check("p4_gap_before", c4, 1);
      tick();
      check("p4_gap_step", c4, 2);

      // Reset with count 7 and prescaler 2
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b1, 8'd7);
      tick();
      ld = 1'b0;
      tick(); tick();
      check("p4_pre_rst", c4, 7);
      rst = 1'b1;
      tick();
      check("p4_mid_rst", c4, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("p4_first_step", c4, (i == 3) ? 1 : 0);
      end

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         ld  = ($urandom_range(0, 9) == 0);
         en  = ($urandom_range(0, 3) != 0);
         up  = $urandom_range(0, 1);
         sat = $urandom_range(0, 1);
         lv  = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 5))
            0:       lim = 8'd0;
            1:       lim = 8'd255;
            default: lim = 8'($urandom_range(1, 20));
         endcase
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
